// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier (signed/unsigned) with a start/done handshake.
// Latency DW+1 cycles, or shorter with EARLY_TERM; i_start is ignored while busy.
module seq_mult #(
  parameter int DW         = 8,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [DW-1:0]   i_mltnd_val,
  input  logic [DW-1:0]   i_mlter_val,
  output logic [2*DW-1:0] o_product,
  output logic            o_done,
  output logic            o_busy
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              neg;
  logic [2*DW-1:0]   mltnd;
  logic [2*DW-1:0]   acc;
  logic [DW-1:0]     mlter;
  logic [CW-1:0]     count;
  logic [DW-1:0]     mag_mltnd;
  logic [DW-1:0]     mag_mlter;
  logic              run_last;

  // Operands are multiplied as magnitudes; the sign is reapplied in FIX.
  always_comb begin
    mag_mltnd = i_mltnd_val;
    mag_mlter = i_mlter_val;
    if (i_signed && i_mltnd_val[DW-1]) mag_mltnd = ~i_mltnd_val + 1'b1;
    if (i_signed && i_mlter_val[DW-1]) mag_mlter = ~i_mlter_val + 1'b1;
  end

  assign run_last = (count == CW'(DW - 1)) ||
                    (EARLY_TERM && ((mlter >> 1) == '0));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == RUN) || (state == FIX);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      neg       <= 1'b0;
      mltnd     <= '0;
      mlter     <= '0;
      acc       <= '0;
      count     <= '0;
      o_product <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= (state == FIX);
      case (state)
        IDLE: begin
          if (i_start) begin
            neg   <= i_signed & (i_mltnd_val[DW-1] ^ i_mlter_val[DW-1]);
            mltnd <= {{DW{1'b0}}, mag_mltnd};
            mlter <= mag_mlter;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          if (mlter[0]) acc <= acc + mltnd;
          mltnd <= mltnd << 1;
          mlter <= mlter >> 1;
          count <= count + 1'b1;
        end
        FIX: begin
          o_product <= neg ? (~acc + 1'b1) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: four instances (DW 8/16 x EARLY_TERM 0/1) share one stimulus
// stream; a cycle-level scoreboard predicts done/busy/product from signed arithmetic.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] ma;
  logic [15:0] mb;

  logic [15:0] p0, p1;
  logic [31:0] p2, p3;
  logic [3:0]  done_v;
  logic [3:0]  busy_v;
  logic [31:0] prod_w [4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  seq_mult #(.DW(8), .EARLY_TERM(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
    .i_mltnd_val(ma[7:0]), .i_mlter_val(mb[7:0]),
    .o_product(p0), .o_done(done_v[0]), .o_busy(busy_v[0]));
  seq_mult #(.DW(8), .EARLY_TERM(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
    .i_mltnd_val(ma[7:0]), .i_mlter_val(mb[7:0]),
    .o_product(p1), .o_done(done_v[1]), .o_busy(busy_v[1]));
  seq_mult #(.DW(16), .EARLY_TERM(1'b0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
    .i_mltnd_val(ma), .i_mlter_val(mb),
    .o_product(p2), .o_done(done_v[2]), .o_busy(busy_v[2]));
  seq_mult #(.DW(16), .EARLY_TERM(1'b1)) u3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn),
    .i_mltnd_val(ma), .i_mlter_val(mb),
    .o_product(p3), .o_done(done_v[3]), .o_busy(busy_v[3]));

  assign prod_w[0] = {16'h0000, p0};
  assign prod_w[1] = {16'h0000, p1};
  assign prod_w[2] = p2;
  assign prod_w[3] = p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dw_of(input int i);
    return (i < 2) ? 8 : 16;
  endfunction

  function automatic bit et_of(input int i);
    return (i % 2) == 1;
  endfunction

  // Operand value as the instance interprets it (low dw bits, optionally signed).
  function automatic longint sx(input int dw, input bit s, input logic [15:0] v);
    longint u;
    u = longint'(v) & ((64'sd1 <<< dw) - 1);
    if (s && u[dw-1]) u = u - (64'sd1 <<< dw);
    return u;
  endfunction

  function automatic logic [31:0] ref_prod(input int dw, input bit s,
                                           input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = sx(dw, s, a) * sx(dw, s, b);
    return 32'(p & ((64'sd1 <<< (2 * dw)) - 1));
  endfunction

  function automatic int ref_lat(input int dw, input bit et, input bit s, input logic [15:0] b);
    longint mag;
    int k;
    if (!et) return dw + 1;
    mag = sx(dw, s, b);
    if (mag < 0) mag = -mag;
    k = 0;
    while ((mag >>> k) != 0) k++;
    if (k < 1) k = 1;
    return k + 1;
  endfunction

  // Scoreboard: per instance, one outstanding operation with its predicted done edge.
  bit          pending [4];
  int          due     [4];
  int          acc_cyc [4];
  int          seen_lat[4];
  logic [31:0] expp    [4];
  logic [31:0] last    [4];
  int          m = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      pending[i] = 1'b0; due[i] = 0; acc_cyc[i] = 0; seen_lat[i] = 0;
      expp[i] = '0; last[i] = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    m++;
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        pending[i] = 1'b0;
        last[i]    = '0;
      end else begin
        if (!pending[i] && start) begin
          pending[i] = 1'b1;
          acc_cyc[i] = m;
          due[i]     = m + ref_lat(dw_of(i), et_of(i), sgn, mb);
          expp[i]    = ref_prod(dw_of(i), sgn, ma, mb);
        end
        chk($sformatf("u%0d done", i), 32'(done_v[i]), 32'(pending[i] && m == due[i]));
        chk($sformatf("u%0d busy", i), 32'(busy_v[i]), 32'(pending[i] && m < due[i]));
        if (pending[i] && m == due[i]) begin
          last[i]     = expp[i];
          seen_lat[i] = m - acc_cyc[i];
          pending[i]  = 1'b0;
        end
        chk($sformatf("u%0d product", i), prod_w[i], last[i]);
      end
    end
  end

  function automatic bit any_pending();
    return pending[0] | pending[1] | pending[2] | pending[3];
  endfunction

  task automatic issue(input bit s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; sgn = s; ma = a; mb = b;
    @(negedge clk);
    start = 1'b0; sgn = 1'($urandom); ma = 16'($urandom); mb = 16'($urandom);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && any_pending(); c++) @(negedge clk);
    if (any_pending()) chk("drain timeout", 32'd1, 32'd0);
  endtask

  task automatic dir(input string tag, input int inst, input bit s,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] ep, input int el);
    issue(s, a, b);
    drain();
    chk({tag, " product"}, prod_w[inst], ep);
    chk({tag, " latency"}, 32'(seen_lat[inst]), 32'(el));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'h8000;
      4:       return 16'h0080;
      5:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; sgn = 1'b0; ma = '0; mb = '0;
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst u%0d done", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst u%0d busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst u%0d product", i), prod_w[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    dir("u255*255", 0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 9);
    dir("u0*0",     0, 1'b0, 16'h0000, 16'h0000, 32'h00000000, 9);
    dir("s-128*-128", 0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 9);
    dir("s-128*127",  0, 1'b1, 16'h0080, 16'h007F, 32'h0000C080, 9);
    dir("s-3*5",      0, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, 9);
    dir("s7*-1",      0, 1'b1, 16'h0007, 16'h00FF, 32'h0000FFF9, 9);
    dir("et200*1",    1, 1'b0, 16'h00C8, 16'h0001, 32'h000000C8, 2);
    dir("et3*0",      1, 1'b0, 16'h0003, 16'h0000, 32'h00000000, 2);
    dir("et1*0x80",   1, 1'b0, 16'h0001, 16'h0080, 32'h00000080, 9);
    dir("et s1*-128", 1, 1'b1, 16'h0001, 16'h0080, 32'h0000FF80, 9);

    // Stray start in the middle of RUN must be ignored.
    issue(1'b0, 16'h0305, 16'h8081);
    repeat (2) @(negedge clk);
    start = 1'b1; sgn = 1'b1; ma = 16'h7777; mb = 16'h3333;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("midrun product", prod_w[0], 32'h00000285);
    chk("midrun latency", 32'(seen_lat[0]), 32'd9);

    // Start held high through the done cycle launches the next operation at once.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; ma = 16'h0012; mb = 16'h0034;
    @(negedge clk);
    ma = 16'h0056; mb = 16'h0078;
    for (int c = 0; c < 30 && !done_v[0]; c++) @(negedge clk);
    chk("b2b first product", prod_w[0], 32'h000003A8);
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("b2b second product", prod_w[0], 32'h00002850);

    // Asynchronous reset in RUN clears outputs immediately.
    issue(1'b0, 16'h0055, 16'h00AA);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrst u%0d busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("midrst u%0d done", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("midrst u%0d product", i), prod_w[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    dir("post-rst 12*13", 0, 1'b0, 16'd12, 16'd13, 32'h0000009C, 9);

    for (int n = 0; n < 1500; n++) begin
      issue(1'($urandom), pick(), pick());
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
